// File: rtl/num_conv_pkg.sv
// Shared definitions for the number-format conversion pipeline.
package num_conv_pkg;

    // Conversion direction, sampled alongside each operand.
    localparam logic MODE_C2_TO_SM = 1'b0;
    localparam logic MODE_SM_TO_C2 = 1'b1;

endpackage : num_conv_pkg

// File: rtl/num_conv_core.sv
// Combinational conversion between two's complement and sign-magnitude.
// The result is one bit wider than the operand so that the most negative
// two's complement value and every sign-magnitude value fit without overflow.
module num_conv_core
    import num_conv_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] data,
    input  logic         mode,
    output logic [W:0]   result,
    output logic         nz
);

    localparam logic [W-1:0] ONE_W  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W:0]   ONE_W1 = {{W{1'b0}}, 1'b1};

    logic         sign;
    logic [W-1:0] c2_mag;
    logic [W:0]   sm_mag;
    logic [W:0]   sm_c2;

    // Both directions are computed, the mode picks one; negative zero maps to 0 with nz set.
    always_comb begin
        sign   = data[W-1];
        c2_mag = sign ? (~data + ONE_W) : data;
        sm_mag = {2'b00, data[W-2:0]};
        sm_c2  = sign ? (~sm_mag + ONE_W1) : sm_mag;
        result = '0;
        nz     = 1'b0;
        if (mode == MODE_C2_TO_SM) begin
            result = {sign, c2_mag};
        end else begin
            result = sm_c2;
            nz     = sign && (data[W-2:0] == '0);
        end
    end

endmodule : num_conv_core

// File: rtl/num_conv_pipe.sv
// Two-stage valid/ready pipeline around num_conv_core.
// S1 holds the raw operand and mode, S2 holds the converted result.
// A running count of negative results delivered downstream saturates
// at all-ones and can be cleared synchronously.
module num_conv_pipe
    import num_conv_pkg::*;
#(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W:0]       out_data,
    output logic             out_nz,
    output logic [CNT_W-1:0] neg_count,
    input  logic             cnt_clr
);

    generate
        if (W < 2 || W > 32) begin : g_bad_width
            $error("num_conv_pipe: W must be in 2..32");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             s1_valid_q, s1_valid_d;
    logic [W-1:0]     s1_data_q,  s1_data_d;
    logic             s1_mode_q,  s1_mode_d;
    logic             s2_valid_q, s2_valid_d;
    logic [W:0]       s2_data_q,  s2_data_d;
    logic             s2_nz_q,    s2_nz_d;
    logic [CNT_W-1:0] neg_count_q, neg_count_d;

    logic         in_xfer;
    logic         out_xfer;
    logic         s2_load;
    logic [W:0]   core_result;
    logic         core_nz;

    num_conv_core #(
        .W (W)
    ) u_core (
        .data   (s1_data_q),
        .mode   (s1_mode_q),
        .result (core_result),
        .nz     (core_nz)
    );

    // Handshake: S2 refills when empty or draining; S1 refills when empty or moving into S2.
    always_comb begin
        in_ready  = rst_n && (!s1_valid_q || !s2_valid_q || out_ready);
        in_xfer   = in_valid && in_ready;
        out_xfer  = s2_valid_q && out_ready;
        s2_load   = s1_valid_q && (!s2_valid_q || out_ready);
        out_valid = s2_valid_q;
        out_data  = s2_data_q;
        out_nz    = s2_nz_q;
        neg_count = neg_count_q;
    end

    // Next state of both stages; stalled stages keep their contents.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_mode_d  = s1_mode_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_nz_d    = s2_nz_q;

        if (in_xfer) begin
            s1_valid_d = 1'b1;
            s1_data_d  = in_data;
            s1_mode_d  = in_mode;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end

        if (s2_load) begin
            s2_valid_d = 1'b1;
            s2_data_d  = core_result;
            s2_nz_d    = core_nz;
        end else if (out_xfer) begin
            s2_valid_d = 1'b0;
        end
    end

    // Negative-result counter; a clear wins over a same-cycle increment.
    always_comb begin
        neg_count_d = neg_count_q;
        if (cnt_clr) begin
            neg_count_d = '0;
        end else if (out_xfer && s2_data_q[W] && (neg_count_q != CNT_MAX)) begin
            neg_count_d = neg_count_q + CNT_ONE;
        end
    end

    // State registers; reset empties the pipe and discards anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_mode_q   <= MODE_C2_TO_SM;
            s2_valid_q  <= 1'b0;
            s2_data_q   <= '0;
            s2_nz_q     <= 1'b0;
            neg_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_mode_q   <= s1_mode_d;
            s2_valid_q  <= s2_valid_d;
            s2_data_q   <= s2_data_d;
            s2_nz_q     <= s2_nz_d;
            neg_count_q <= neg_count_d;
        end
    end

endmodule : num_conv_pipe

// File: tb/tb_num_conv_pipe.sv
// Bench for num_conv_pipe at W=4, CNT_W=4.
module tb_num_conv_pipe;

    localparam int W     = 4;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_mode = 1'b0;
    logic             out_ready = 1'b0;
    logic             cnt_clr = 1'b0;
    logic [W-1:0]     in_data = '0;
    logic             in_ready;
    logic             out_valid;
    logic             out_nz;
    logic [W:0]       out_data;
    logic [CNT_W-1:0] neg_count;

    int n_cmp = 0;
    int n_fail = 0;
    int exp_data[$];
    bit exp_nz[$];
    int obs_data[$];
    bit obs_nz[$];
    int acc_cyc[$];
    int obs_cyc[$];
    int cyc = 0;
    int model_cnt = 0;

    logic             s_in_ready;
    logic             s_out_valid;
    logic             s_out_nz;
    logic [W:0]       s_out_data;
    logic [CNT_W-1:0] s_neg_count;

    always #5 clk = ~clk;

    num_conv_pipe #(
        .W     (W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_nz    (out_nz),
        .neg_count (neg_count),
        .cnt_clr   (cnt_clr)
    );

    // Reference conversion from the number formats themselves.
    function automatic void model(input int d, input int m, output int r, output bit nz);
        int v;
        int mag;
        nz = 1'b0;
        if (m == 0) begin
            v = (d >= (1 << (W-1))) ? d - (1 << W) : d;
            r = (v < 0) ? (1 << W) + (-v) : v;
        end else begin
            mag = d % (1 << (W-1));
            v   = (d >= (1 << (W-1))) ? -mag : mag;
            r   = v & ((1 << (W+1)) - 1);
            nz  = (d >= (1 << (W-1))) && (mag == 0);
        end
    endfunction

    task automatic clear_model();
        exp_data.delete(); exp_nz.delete();
        obs_data.delete(); obs_nz.delete();
        acc_cyc.delete();  obs_cyc.delete();
        model_cnt = 0;
    endtask

    // One clock: drive at negedge, sample 1 time unit later, log transfers.
    task automatic cycle(input bit v, input int d, input bit m, input bit ordy, input bit clr);
        int r;
        bit z;
        bit neg;
        @(negedge clk);
        in_valid = v; in_data = d[W-1:0]; in_mode = m; out_ready = ordy; cnt_clr = clr;
        #1;
        s_in_ready = in_ready; s_out_valid = out_valid; s_out_data = out_data;
        s_out_nz = out_nz; s_neg_count = neg_count;
        if (v && in_ready) begin
            model(d, int'(m), r, z);
            exp_data.push_back(r); exp_nz.push_back(z); acc_cyc.push_back(cyc);
        end
        if (out_valid && ordy) begin
            neg = (obs_data.size() < exp_data.size()) ? (exp_data[obs_data.size()] >= (1 << W))
                                                      : out_data[W];
            obs_data.push_back(int'(out_data)); obs_nz.push_back(out_nz); obs_cyc.push_back(cyc);
            if (!clr && neg && model_cnt < CMAX) model_cnt++;
        end
        if (clr) model_cnt = 0;
        cyc++;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
        #1;
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_data = 4'b1011;
        #1;
        n_cmp += 5;
        if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        if (out_data !== '0)    begin n_fail++; $display("FAIL rst_out_data got=%b want=0", out_data); end
        if (out_nz !== 1'b0)    begin n_fail++; $display("FAIL rst_out_nz got=%b want=0", out_nz); end
        if (neg_count !== '0)   begin n_fail++; $display("FAIL rst_neg_count got=%0d want=0", neg_count); end
        @(negedge clk);
        n_cmp += 2;
        if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL rst_hold_in_ready got=%b want=0", in_ready); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_hold_out_valid got=%b want=0", out_valid); end
        rst_n = 1'b1; in_valid = 1'b0;
        clear_model();
        cycle(1'b0, 0, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (s_in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_ready got=%b want=1", s_in_ready); end
    endtask

    task automatic test_mode0();
        int din[4]  = '{11, 8, 3, 0};
        int want[4] = '{21, 24, 3, 0};
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, din[i], 1'b0, 1'b1, 1'b0);
        drain(6);
        n_cmp++;
        if (obs_data.size() != 4) begin n_fail++; $display("FAIL m0_count got=%0d want=4", obs_data.size()); end
        for (int i = 0; i < 4 && i < obs_data.size(); i++) begin
            n_cmp += 3;
            if (obs_data[i] !== want[i]) begin n_fail++; $display("FAIL m0_data[%0d] got=%b want=%b", i, obs_data[i][4:0], want[i][4:0]); end
            if (obs_nz[i] !== 1'b0) begin n_fail++; $display("FAIL m0_nz[%0d] got=%b want=0", i, obs_nz[i]); end
            if (obs_cyc[i] - acc_cyc[0] !== 2 + i) begin n_fail++; $display("FAIL m0_latency[%0d] got=%0d want=%0d", i, obs_cyc[i] - acc_cyc[0], 2 + i); end
        end
        n_cmp++;
        if (neg_count !== 4'd2) begin n_fail++; $display("FAIL m0_neg_count got=%0d want=2", neg_count); end
    endtask

    task automatic test_mode1();
        int din[3]  = '{13, 8, 7};
        int want[3] = '{27, 0, 7};
        bit wnz[3]  = '{1'b0, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, din[i], 1'b1, 1'b1, 1'b0);
        drain(6);
        n_cmp++;
        if (obs_data.size() != 3) begin n_fail++; $display("FAIL m1_count got=%0d want=3", obs_data.size()); end
        for (int i = 0; i < 3 && i < obs_data.size(); i++) begin
            n_cmp += 2;
            if (obs_data[i] !== want[i]) begin n_fail++; $display("FAIL m1_data[%0d] got=%b want=%b", i, obs_data[i][4:0], want[i][4:0]); end
            if (obs_nz[i] !== wnz[i]) begin n_fail++; $display("FAIL m1_nz[%0d] got=%b want=%b", i, obs_nz[i], wnz[i]); end
        end
        n_cmp++;
        if (neg_count !== 4'd1) begin n_fail++; $display("FAIL m1_neg_count got=%0d want=1", neg_count); end
    endtask

    task automatic test_backpressure();
        int words[3];
        int w = 0;
        bit held = 1'b0;
        logic [W:0] held_data = '0;
        do_reset();
        for (int i = 0; i < 3; i++) words[i] = int'($urandom_range(0, 15));
        for (int k = 0; k < 5; k++) begin
            cycle(w < 3, (w < 3) ? words[w] : 0, 1'b0, 1'b0, 1'b0);
            if (w < 3 && s_in_ready) w++;
            if (s_out_valid) begin
                if (held) begin
                    n_cmp++;
                    if (s_out_data !== held_data) begin n_fail++; $display("FAIL bp_stable got=%b want=%b", s_out_data, held_data); end
                end
                held = 1'b1; held_data = s_out_data;
            end
        end
        n_cmp += 2;
        if (exp_data.size() != 2) begin n_fail++; $display("FAIL bp_accepted got=%0d want=2", exp_data.size()); end
        if (!held) begin n_fail++; $display("FAIL bp_out_valid got=0 want=1"); end
        for (int k = 0; k < 10 && w < 3; k++) begin
            cycle(1'b1, words[w], 1'b0, 1'b1, 1'b0);
            if (s_in_ready) w++;
        end
        drain(6);
        n_cmp++;
        if (obs_data.size() != 3) begin n_fail++; $display("FAIL bp_delivered got=%0d want=3", obs_data.size()); end
        for (int i = 0; i < 3 && i < obs_data.size(); i++) begin
            int r;
            bit z;
            model(words[i], 0, r, z);
            n_cmp++;
            if (obs_data[i] !== r) begin n_fail++; $display("FAIL bp_order[%0d] got=%0d want=%0d", i, obs_data[i], r); end
        end
    endtask

    task automatic test_counter();
        bit seen = 1'b0;
        do_reset();
        for (int i = 0; i < 17; i++) cycle(1'b1, 8 + int'($urandom_range(0, 7)), 1'b0, 1'b1, 1'b0);
        drain(6);
        n_cmp += 2;
        if (obs_data.size() != 17) begin n_fail++; $display("FAIL cnt_delivered got=%0d want=17", obs_data.size()); end
        if (neg_count !== 4'd15) begin n_fail++; $display("FAIL cnt_saturate got=%0d want=15", neg_count); end
        cycle(1'b1, 9, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 0, 1'b0, 1'b0, 1'b0);
            if (s_out_valid) begin seen = 1'b1; break; end
        end
        n_cmp++;
        if (!seen) begin n_fail++; $display("FAIL cnt_wait_valid got=timeout want=out_valid"); end
        cycle(1'b0, 0, 1'b0, 1'b1, 1'b1);
        drain(2);
        n_cmp += 2;
        if (obs_data.size() != 18) begin n_fail++; $display("FAIL cnt_clr_xfer got=%0d want=18", obs_data.size()); end
        if (neg_count !== 4'd0) begin n_fail++; $display("FAIL cnt_clr_priority got=%0d want=0", neg_count); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        cycle(1'b1, 12, 1'b0, 1'b1, 1'b0);
        drain(4);
        n_cmp++;
        if (neg_count !== 4'd1) begin n_fail++; $display("FAIL mid_pre_count got=%0d want=1", neg_count); end
        cycle(1'b1, 10, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 5, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_inflight got=%b want=1", out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp += 3;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_async_valid got=%b want=0", out_valid); end
        if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL mid_async_ready got=%b want=0", in_ready); end
        if (neg_count !== '0)   begin n_fail++; $display("FAIL mid_async_count got=%0d want=0", neg_count); end
        @(negedge clk);
        rst_n = 1'b1;
        clear_model();
        drain(6);
        n_cmp++;
        if (obs_data.size() != 0) begin n_fail++; $display("FAIL mid_stale got=%0d want=0", obs_data.size()); end
    endtask

    task automatic test_random();
        bit pend_v = 1'b0;
        int pend_d = 0;
        bit pend_m = 1'b0;
        bit ordy;
        bit clr;
        bit prev_stall = 1'b0;
        logic [W:0] prev_data = '0;
        int m_prev;
        do_reset();
        for (int k = 0; k < 10000; k++) begin
            if (!pend_v && ($urandom_range(0, 3) != 0)) begin
                pend_v = 1'b1;
                pend_d = int'($urandom_range(0, 15));
                pend_m = 1'($urandom_range(0, 1));
            end
            ordy   = ($urandom_range(0, 2) != 0);
            clr    = ($urandom_range(0, 63) == 0);
            m_prev = model_cnt;
            cycle(pend_v, pend_d, pend_m, ordy, clr);
            n_cmp++;
            if (s_neg_count !== m_prev[CNT_W-1:0]) begin n_fail++; $display("FAIL rnd_count@%0d got=%0d want=%0d", k, s_neg_count, m_prev); end
            if (prev_stall) begin
                n_cmp++;
                if (!s_out_valid || s_out_data !== prev_data) begin
                    n_fail++; $display("FAIL rnd_hold@%0d got=%b/%b want=1/%b", k, s_out_valid, s_out_data, prev_data);
                end
            end
            prev_stall = s_out_valid && !ordy;
            prev_data  = s_out_data;
            if (pend_v && s_in_ready) pend_v = 1'b0;
        end
        drain(6);
        n_cmp += 2;
        if (obs_data.size() != exp_data.size()) begin n_fail++; $display("FAIL rnd_count_words got=%0d want=%0d", obs_data.size(), exp_data.size()); end
        if (neg_count !== model_cnt[CNT_W-1:0]) begin n_fail++; $display("FAIL rnd_final_count got=%0d want=%0d", neg_count, model_cnt); end
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            n_cmp++;
            if (obs_data[i] !== exp_data[i] || obs_nz[i] !== exp_nz[i]) begin
                n_fail++; $display("FAIL rnd_word[%0d] got=%0d/%b want=%0d/%b", i, obs_data[i], obs_nz[i], exp_data[i], exp_nz[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode1();
        test_backpressure();
        test_counter();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_num_conv_pipe
